// File: rtl/nn_pf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pf_pkg
// Description : Register offsets, ID value and bus FSM states for the
//               platform I/O responder.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pf_pkg;

    localparam logic [3:0]  PF_OFF_KEY = 4'h0;
    localparam logic [3:0]  PF_OFF_LED = 4'h4;
    localparam logic [3:0]  PF_OFF_EVT = 4'h8;
    localparam logic [3:0]  PF_OFF_ID  = 4'hC;

    localparam logic [31:0] PF_ID      = 32'h6E6E_0001;

    typedef enum logic [0:0] {
        PF_IDLE = 1'b0,
        PF_RESP = 1'b1
    } pf_state_t;

endpackage
`default_nettype wire

// File: rtl/nn_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : nn_key_debounce
// Description : Two-flop synchronizer plus counter debounce for one key,
//               with a pulse on the edge where the stable level rises.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_key_debounce
    import nn_pf_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_CW     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [DEB_CW-1:0] c_last = DEB_CW'(DEB_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_stable;
    logic [DEB_CW-1:0] r_cnt;
    logic              w_differ;
    logic              w_accept;

    assign w_differ = r_sync2 ^ r_stable;
    assign w_accept = w_differ && (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Rise is flagged on the same edge that promotes the new stable level.
    assign o_stable = r_stable;
    assign o_rise   = w_accept & r_sync2;

endmodule
`default_nettype wire

// File: rtl/nn_pf_io_resp.sv
`default_nettype none
// ============================================================================
// Module      : nn_pf_io_resp
// Description : Platform I/O window responder: KEY/LED/event/ID registers
//               behind a registered single-beat req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_pf_io_resp
    import nn_pf_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          KEY_W      = 2,
    parameter int          LED_W      = 8,
    parameter int          DEB_CYCLES = 50000,
    parameter int          DEB_CW     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ack,
    output logic             err,
    input  logic [KEY_W-1:0] KEY,
    output logic [LED_W-1:0] LED,
    output logic             irq
);

    pf_state_t        r_state;
    pf_state_t        w_state_next;

    logic [KEY_W-1:0] w_stable;
    logic [KEY_W-1:0] w_rise;
    logic [KEY_W-1:0] r_evt;
    logic [KEY_W-1:0] w_evt_next;
    logic [KEY_W-1:0] w_clr;
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_rdata;
    logic             r_ack;
    logic             r_err;
    logic             r_irq;

    logic             w_take;
    logic             w_hit;
    logic [31:0]      w_rd_data;
    logic             w_err;
    logic             w_led_wr;
    logic             w_evt_rd;
    logic             w_evt_wr;

    generate
        for (genvar k = 0; k < KEY_W; k++) begin : g_key
            nn_key_debounce #(
                .DEB_CYCLES (DEB_CYCLES),
                .DEB_CW     (DEB_CW)
            ) u_deb (
                .clk      (CLK),
                .rst_n    (RST_N),
                .i_key    (KEY[k]),
                .o_stable (w_stable[k]),
                .o_rise   (w_rise[k])
            );
        end
    endgenerate

    // Only aligned words inside the 16-byte window decode; all four map.
    assign w_hit  = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
    assign w_take = (r_state == PF_IDLE) && req;

    always_comb begin
        w_rd_data = 32'h0;
        w_err     = !w_hit;
        if (w_hit && !we) begin
            case (addr[3:0])
                PF_OFF_KEY: w_rd_data = 32'(w_stable);
                PF_OFF_LED: w_rd_data = 32'(r_led);
                PF_OFF_EVT: w_rd_data = 32'(r_evt);
                PF_OFF_ID:  w_rd_data = PF_ID;
                default:    w_rd_data = 32'h0;
            endcase
        end
    end

    assign w_led_wr = w_take &&  we && w_hit && (addr[3:0] == PF_OFF_LED);
    assign w_evt_wr = w_take &&  we && w_hit && (addr[3:0] == PF_OFF_EVT);
    assign w_evt_rd = w_take && !we && w_hit && (addr[3:0] == PF_OFF_EVT);

    // A new rise wins over a clear landing on the same bit.
    assign w_clr      = (w_evt_rd ? r_evt : '0) | (w_evt_wr ? wdata[KEY_W-1:0] : '0);
    assign w_evt_next = (r_evt & ~w_clr) | w_rise;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= PF_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PF_IDLE: if (req) w_state_next = PF_RESP;
            PF_RESP: w_state_next = PF_IDLE;
            default: w_state_next = PF_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_evt   <= '0;
            r_irq   <= 1'b0;
            r_led   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_evt <= w_evt_next;
            r_irq <= |w_evt_next;
            r_ack <= w_take;
            if (w_led_wr) begin
                r_led <= wdata[LED_W-1:0];
            end
            if (w_take) begin
                r_rdata <= w_rd_data;
                r_err   <= w_err;
            end
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;
    assign LED   = r_led;
    assign irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_nn_pf_io_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_pf_io_resp
// Description : Directed vector table plus hand-written key/event/reset
//               sequences for the platform I/O responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_pf_io_resp;

    localparam logic [31:0] c_base = 32'h8000_0000;

    logic        CLK;
    logic        RST_N;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [1:0]  KEY;
    logic [7:0]  LED;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    nn_pf_io_resp #(
        .BASE_ADDR  (c_base),
        .KEY_W      (2),
        .LED_W      (8),
        .DEB_CYCLES (4),
        .DEB_CW     (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .KEY   (KEY),
        .LED   (LED),
        .irq   (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one access, wait a bounded time for ack, then confirm ack drops.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
        logic ok;
        ok  = 1'b0;
        rd  = 32'hDEAD_BEEF;
        e   = 1'bx;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (ack) begin
                ok = 1'b1;
                rd = rdata;
                e  = err;
                break;
            end
        end
        req = 1'b0;
        chk("ack_seen", 32'(ok), 32'd1);
        @(posedge CLK); #1;
        chk("ack_one_cycle", 32'(ack), 32'd0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;

        vecs[0] = '{1'b0, c_base + 32'hC, 32'h0,         32'h6E6E_0001, 1'b0, 8'h00};
        vecs[1] = '{1'b1, c_base + 32'h4, 32'h0000_01A5, 32'h0,         1'b0, 8'hA5};
        vecs[2] = '{1'b0, c_base + 32'h4, 32'h0,         32'h0000_00A5, 1'b0, 8'hA5};
        vecs[3] = '{1'b0, c_base + 32'h0, 32'h0,         32'h0,         1'b0, 8'hA5};
        vecs[4] = '{1'b1, c_base + 32'h0, 32'hFFFF_FFFF, 32'h0,         1'b0, 8'hA5};
        vecs[5] = '{1'b1, c_base + 32'hC, 32'hFFFF_FFFF, 32'h0,         1'b0, 8'hA5};
        vecs[6] = '{1'b0, c_base + 32'h10, 32'h0,        32'h0,         1'b1, 8'hA5};
        vecs[7] = '{1'b0, c_base + 32'h6, 32'h0,         32'h0,         1'b1, 8'hA5};
        vecs[8] = '{1'b1, 32'h9000_0004,  32'h0000_0033, 32'h0,         1'b1, 8'hA5};
        vecs[9] = '{1'b1, c_base + 32'h5, 32'h0000_0077, 32'h0,         1'b1, 8'hA5};

        RST_N = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; KEY = 2'b00;
        wait_cyc(3);
        chk("rst_led", 32'(LED), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        RST_N = 1'b1;
        wait_cyc(2);
        chk("idle_ack", 32'(ack), 32'h0);

        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_led", i), 32'(LED), 32'(vecs[i].exp_led));
        end

        // Glitch of three cycles must not change the stable key.
        @(posedge CLK); #1; KEY = 2'b01;
        wait_cyc(3);        KEY = 2'b00;
        wait_cyc(6);
        xfer(1'b0, c_base + 32'h0, 32'h0, rd, e);
        chk("glitch_key_in", rd, 32'h0);
        chk("glitch_irq", 32'(irq), 32'h0);

        KEY = 2'b01;
        wait_cyc(10);
        chk("press_irq", 32'(irq), 32'h1);
        xfer(1'b0, c_base + 32'h0, 32'h0, rd, e);
        chk("press_key_in", rd, 32'h1);
        xfer(1'b0, c_base + 32'h8, 32'h0, rd, e);
        chk("evt_read1", rd, 32'h1);
        xfer(1'b0, c_base + 32'h8, 32'h0, rd, e);
        chk("evt_read2", rd, 32'h0);
        chk("evt_clr_irq", 32'(irq), 32'h0);

        // Both keys pressed, then W1C clears only bit 0.
        KEY = 2'b00;
        wait_cyc(10);
        KEY = 2'b11;
        wait_cyc(10);
        xfer(1'b1, c_base + 32'h8, 32'h1, rd, e);
        chk("w1c_err", 32'(e), 32'h0);
        chk("w1c_irq", 32'(irq), 32'h1);
        xfer(1'b0, c_base + 32'h8, 32'h0, rd, e);
        chk("w1c_evt", rd, 32'h2);
        chk("w1c_irq_after_read", 32'(irq), 32'h0);

        // Rise of KEY[1] on the same edge that samples a KEY_EVT read.
        KEY = 2'b00;
        wait_cyc(10);
        @(posedge CLK); #1; KEY = 2'b10;
        wait_cyc(5);
        xfer(1'b0, c_base + 32'h8, 32'h0, rd, e);
        chk("race_read_old", rd, 32'h0);
        chk("race_irq", 32'(irq), 32'h1);
        xfer(1'b0, c_base + 32'h8, 32'h0, rd, e);
        chk("race_evt_set", rd, 32'h2);
        KEY = 2'b00;

        // Reset during the response cycle of a store.
        @(posedge CLK); #1;
        req = 1'b1; we = 1'b1; addr = c_base + 32'h4; wdata = 32'h3C;
        @(posedge CLK); #1;
        chk("mid_ack", 32'(ack), 32'h1);
        chk("mid_led", 32'(LED), 32'h3C);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_led", 32'(LED), 32'h0);
        req = 1'b0;
        wait_cyc(1);
        RST_N = 1'b1;
        wait_cyc(1);
        xfer(1'b0, c_base + 32'hC, 32'h0, rd, e);
        chk("post_rst_id", rd, 32'h6E6E_0001);
        chk("post_rst_err", 32'(e), 32'h0);

        // req held high for five cycles: ack only in cycles 2 and 4.
        req = 1'b1; we = 1'b0; addr = c_base + 32'hC; wdata = 32'h0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("b2b_cyc%0d_ack", c), 32'(ack), (c == 2 || c == 4) ? 32'h1 : 32'h0);
            @(posedge CLK); #1;
        end
        req = 1'b0;
        wait_cyc(3);
        chk("b2b_drain_ack", 32'(ack), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
